// File: rtl/piezo_alert_sched.sv
// piezo_alert_sched: alert-tune scheduler for the piezo path.
// Arbitrates too_fast / batt_low / en_steer requests, picks a tune and hands one note at a time
// (period, duration) to the tone generator over a valid/ready handshake, then waits for the
// generator's done pulse. Owns the repeat timer that spaces batt/steer tunes apart.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   too_fast_i     overspeed request (highest priority)
//   batt_low_i     low-battery request
//   en_steer_i     steering-enabled request (lowest priority)
//   tone_rdy_i     tone generator can accept a note
//   tone_done_i    1-cycle pulse: current note finished
//   tone_vld_o     note offered; tone_period_o / tone_dur_o valid
//   tone_period_o  note period in clk cycles (scaled)
//   tone_dur_o     note duration in clk cycles (scaled)
//   alert_id_o     active tune: 00 none, 01 steer, 10 batt, 11 too_fast
//   busy_o         high whenever a tune is in progress
module piezo_alert_sched #(
  parameter int unsigned FAST_SIM     = 1,
  parameter int unsigned REP_CYC      = 150_000_000,
  parameter int unsigned FAST_REP_CYC = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        too_fast_i,
  input  logic        batt_low_i,
  input  logic        en_steer_i,
  input  logic        tone_rdy_i,
  input  logic        tone_done_i,
  output logic        tone_vld_o,
  output logic [14:0] tone_period_o,
  output logic [24:0] tone_dur_o,
  output logic [1:0]  alert_id_o,
  output logic        busy_o
);

  localparam int unsigned Shift   = (FAST_SIM != 0) ? 9 : 0;
  localparam logic [27:0] RepLoad = (FAST_SIM != 0) ? 28'(FAST_REP_CYC) : 28'(REP_CYC);

  typedef enum logic [1:0] {StIdle, StIssue, StPlay} state_e;
  typedef enum logic [1:0] {
    AlNone  = 2'b00,
    AlSteer = 2'b01,
    AlBatt  = 2'b10,
    AlFast  = 2'b11
  } alert_e;

  state_e      state_q, state_d;
  alert_e      alert_q, alert_d;
  logic [2:0]  pos_q, pos_d;
  logic [27:0] timer_q, timer_d;

  logic [2:0]  note;
  logic [14:0] base_period;
  logic [24:0] base_dur;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      alert_q <= AlNone;
      pos_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      alert_q <= alert_d;
      pos_q   <= pos_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    alert_d = alert_q;
    pos_d   = pos_q;
    // Saturating countdown; runs in every state, including during too_fast tunes
    timer_d = (timer_q != '0) ? timer_q - 28'd1 : '0;

    case (state_q)
      StIdle: begin
        // too_fast bypasses the repeat timer; the others wait for it to expire
        if (too_fast_i) begin
          state_d = StIssue;
          alert_d = AlFast;
          pos_d   = '0;
        end else if (timer_q == '0 && batt_low_i) begin
          state_d = StIssue;
          alert_d = AlBatt;
          pos_d   = '0;
        end else if (timer_q == '0 && en_steer_i) begin
          state_d = StIssue;
          alert_d = AlSteer;
          pos_d   = '0;
        end
      end
      StIssue: begin
        if (tone_rdy_i) state_d = StPlay;
      end
      StPlay: begin
        if (tone_done_i) begin
          if (too_fast_i && alert_q != AlFast) begin
            // Preempt only at a note boundary
            state_d = StIssue;
            alert_d = AlFast;
            pos_d   = '0;
          end else if (alert_q == AlFast && pos_q == 3'd2) begin
            if (too_fast_i) begin
              state_d = StIssue;
              pos_d   = '0;
            end else begin
              state_d = StIdle;
              alert_d = AlNone;
              pos_d   = '0;
            end
          end else if (alert_q != AlFast && pos_q == 3'd5) begin
            state_d = StIdle;
            alert_d = AlNone;
            pos_d   = '0;
            timer_d = RepLoad;
          end else begin
            state_d = StIssue;
            pos_d   = pos_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Batt tune walks the table backwards
  always_comb begin
    note = (alert_q == AlBatt) ? (3'd5 - pos_q) : pos_q;
  end

  // Note table (unscaled)
  always_comb begin
    base_period = '0;
    base_dur    = '0;
    unique case (note)
      3'd0: begin base_period = 15'd31888; base_dur = 25'd8388608;  end
      3'd1: begin base_period = 15'd23890; base_dur = 25'd8388608;  end
      3'd2: begin base_period = 15'd18961; base_dur = 25'd8388608;  end
      3'd3: begin base_period = 15'd15944; base_dur = 25'd12582912; end
      3'd4: begin base_period = 15'd18961; base_dur = 25'd4194304;  end
      3'd5: begin base_period = 15'd15944; base_dur = 25'd16777216; end
      default: begin base_period = '0; base_dur = '0; end
    endcase
  end

  // Outputs; period/dur forced to zero while idle so reset/idle values are clean
  always_comb begin
    tone_vld_o    = (state_q == StIssue);
    busy_o        = (state_q != StIdle);
    tone_period_o = busy_o ? (base_period >> Shift) : '0;
    tone_dur_o    = busy_o ? (base_dur >> Shift) : '0;
    alert_id_o    = alert_q;
  end

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Bench for piezo_alert_sched: two instances (scaled FAST_SIM=1 with default repeat interval,
// and unscaled FAST_SIM=0 with a short REP_CYC) checked every cycle against a tune-level model,
// plus directed scenarios with literal expectations, then randomized requests/handshakes.
module tb_piezo_alert_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic tf, bl, es;
  logic rdy [2];
  logic done [2];
  logic        vld   [2];
  logic [14:0] per   [2];
  logic [24:0] dur   [2];
  logic [1:0]  alert [2];
  logic        busy  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cnt [2];

  // Index 0: unscaled, short repeat; index 1: scaled, default repeat
  localparam int Interval [2] = '{300, 5000};
  localparam int Scale    [2] = '{0, 9};

  int steer_p [6] = '{62, 46, 37, 31, 37, 31};
  int steer_d [6] = '{16384, 16384, 16384, 24576, 8192, 32768};
  int batt_p  [6] = '{31, 37, 31, 37, 46, 62};
  int batt_d  [6] = '{32768, 8192, 24576, 16384, 16384, 16384};

  always #5 clk = ~clk;

  piezo_alert_sched #(.FAST_SIM(0), .REP_CYC(300), .FAST_REP_CYC(5000)) u_dut_slow (
    .clk          (clk),
    .rst_n        (rst_n),
    .too_fast_i   (tf),
    .batt_low_i   (bl),
    .en_steer_i   (es),
    .tone_rdy_i   (rdy[0]),
    .tone_done_i  (done[0]),
    .tone_vld_o   (vld[0]),
    .tone_period_o(per[0]),
    .tone_dur_o   (dur[0]),
    .alert_id_o   (alert[0]),
    .busy_o       (busy[0])
  );

  piezo_alert_sched #(.FAST_SIM(1), .REP_CYC(150_000_000), .FAST_REP_CYC(5000)) u_dut_fast (
    .clk          (clk),
    .rst_n        (rst_n),
    .too_fast_i   (tf),
    .batt_low_i   (bl),
    .en_steer_i   (es),
    .tone_rdy_i   (rdy[1]),
    .tone_done_i  (done[1]),
    .tone_vld_o   (vld[1]),
    .tone_period_o(per[1]),
    .tone_dur_o   (dur[1]),
    .alert_id_o   (alert[1]),
    .busy_o       (busy[1])
  );

  // ---------------- tune-level model ----------------
  // phase: 0 idle, 1 note offered, 2 note playing; tune: 0 none, 1 steer, 2 batt, 3 too_fast
  typedef struct {
    int phase;
    int tune;
    int pos;
    int timer;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t mreset();
    mdl_t r;
    r.phase = 0; r.tune = 0; r.pos = 0; r.timer = 0;
    return r;
  endfunction

  function automatic int tune_len(input int t);
    return (t == 3) ? 3 : 6;
  endfunction

  // steer plays N0..N5, batt N5..N0, too_fast N0..N2
  function automatic int note_of(input int t, input int p);
    return (t == 2) ? 5 - p : p;
  endfunction

  function automatic longint base_per(input int n);
    case (n)
      0: return 31888;
      1: return 23890;
      2, 4: return 18961;
      3, 5: return 15944;
      default: return 0;
    endcase
  endfunction

  function automatic longint base_dur(input int n);
    case (n)
      0, 1, 2: return 64'd8388608;
      3: return 64'd12582912;
      4: return 64'd4194304;
      5: return 64'd16777216;
      default: return 0;
    endcase
  endfunction

  function automatic mdl_t mnext(input mdl_t s, input bit rstv, input bit tfv, input bit blv,
                                 input bit esv, input bit rdyv, input bit donev, input int ivl);
    mdl_t n;
    if (!rstv) return mreset();
    n = s;
    if (s.timer > 0) n.timer = s.timer - 1;
    if (s.phase == 0) begin
      if (tfv) begin n.phase = 1; n.tune = 3; n.pos = 0; end
      else if (s.timer == 0 && blv) begin n.phase = 1; n.tune = 2; n.pos = 0; end
      else if (s.timer == 0 && esv) begin n.phase = 1; n.tune = 1; n.pos = 0; end
    end else if (s.phase == 1) begin
      if (rdyv) n.phase = 2;
    end else if (donev) begin
      if (tfv && s.tune != 3) begin
        n.tune = 3; n.pos = 0; n.phase = 1;
      end else if (s.pos == tune_len(s.tune) - 1) begin
        if (s.tune == 3 && tfv) begin
          n.pos = 0; n.phase = 1;
        end else begin
          if (s.tune != 3) n.timer = ivl;
          n.phase = 0; n.tune = 0; n.pos = 0;
        end
      end else begin
        n.pos = s.pos + 1; n.phase = 1;
      end
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      longint ep, ed;
      bit eb;
      eb = (m[i].phase != 0);
      ep = eb ? (base_per(note_of(m[i].tune, m[i].pos)) >> Scale[i]) : 0;
      ed = eb ? (base_dur(note_of(m[i].tune, m[i].pos)) >> Scale[i]) : 0;
      chk($sformatf("vld[%0d]", i), vld[i], (m[i].phase == 1) ? 1 : 0);
      chk($sformatf("busy[%0d]", i), busy[i], eb ? 1 : 0);
      chk($sformatf("alert[%0d]", i), alert[i], m[i].tune);
      chk($sformatf("period[%0d]", i), per[i], ep);
      chk($sformatf("dur[%0d]", i), dur[i], ed);
    end
  endtask

  // Advance one clock: model absorbs the inputs the DUT samples at the coming edge
  task automatic step();
    for (int i = 0; i < 2; i++)
      m[i] = mnext(m[i], rst_n, tf, bl, es, rdy[i], done[i], Interval[i]);
    @(negedge clk);
    compare();
  endtask

  task automatic tg(input logic r, input logic d);
    rdy[0] = r; rdy[1] = r; done[0] = d; done[1] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_vld", vld[1], 0);
    chk("rst_busy", busy[1], 0);
    chk("rst_alert", alert[1], 0);
    chk("rst_period", per[1], 0);
    chk("rst_dur", dur[1], 0);
    m[0] = mreset();
    m[1] = mreset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Precondition: note offered on the scaled instance with rdy=1. tf_after >= 0 drives too_fast
  // once the note is playing.
  task automatic play_note(input int p, input int d, input int a, input int tf_after);
    chk("note_vld", vld[1], 1);
    chk("note_period", per[1], p);
    chk("note_dur", dur[1], d);
    chk("note_alert", alert[1], a);
    step();
    chk("note_vld_drop", vld[1], 0);
    if (tf_after >= 0) tf = (tf_after != 0);
    step();
    step();
    tg(1'b1, 1'b1);
    step();
    tg(1'b1, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    tf = 1'b0; bl = 1'b0; es = 1'b0;
    tg(1'b0, 1'b0);
    cnt[0] = 0; cnt[1] = 0;
    m[0] = mreset();
    m[1] = mreset();
    @(negedge clk);

    // Steer tune, values and repeat spacing
    do_reset();
    step();
    es = 1'b1;
    tg(1'b1, 1'b0);
    step();
    chk("t1_first_vld", vld[1], 1);
    chk("t1_slow_period", per[0], 31888);
    chk("t1_slow_dur", dur[0], 8388608);
    for (int k = 0; k < 6; k++) play_note(steer_p[k], steer_d[k], 1, -1);
    chk("t1_idle_busy", busy[1], 0);
    n = 0;
    while (!vld[1] && n < 6000) begin
      step();
      n++;
    end
    chk("t1_repeat_gap", n, 5001);
    es = 1'b0;

    // batt beats steer
    do_reset();
    bl = 1'b1;
    es = 1'b1;
    step();
    for (int k = 0; k < 6; k++) play_note(batt_p[k], batt_d[k], 2, -1);
    chk("t2_idle_busy", busy[1], 0);
    bl = 1'b0;
    es = 1'b0;

    // too_fast preempts at note boundary, loops, finishes pass when dropped
    do_reset();
    es = 1'b1;
    step();
    es = 1'b0;
    play_note(62, 16384, 1, -1);
    play_note(46, 16384, 1, -1);
    play_note(37, 16384, 1, 1);
    play_note(62, 16384, 3, -1);
    play_note(46, 16384, 3, -1);
    play_note(37, 16384, 3, -1);
    play_note(62, 16384, 3, -1);
    play_note(46, 16384, 3, 0);
    play_note(37, 16384, 3, -1);
    chk("t3_idle_busy", busy[1], 0);
    chk("t3_idle_alert", alert[1], 0);

    // Backpressure holds the offer stable
    do_reset();
    tg(1'b0, 1'b0);
    es = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_vld", vld[1], 1);
      chk("t4_hold_period", per[1], 62);
      chk("t4_hold_dur", dur[1], 16384);
      step();
    end
    tg(1'b1, 1'b0);
    step();
    chk("t4_accept_vld", vld[1], 0);
    chk("t4_accept_busy", busy[1], 1);
    es = 1'b0;

    // Reset mid-note
    do_reset();
    es = 1'b1;
    step();
    for (int k = 0; k < 3; k++) play_note(steer_p[k], steer_d[k], 1, -1);
    step();
    step();
    chk("t5_playing", busy[1], 1);
    do_reset();
    step();
    chk("t5_restart_vld", vld[1], 1);
    chk("t5_restart_period", per[1], 62);
    chk("t5_restart_alert", alert[1], 1);
    es = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 30000; c++) begin
      rst_n = ($urandom_range(0, 4999) != 0);
      if ($urandom_range(0, 59) == 0) tf = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) bl = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 59) == 0) es = $urandom_range(0, 1) != 0;
      for (int i = 0; i < 2; i++) begin
        done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) done[i] = 1'b1;
        end else if ($urandom_range(0, 63) == 0) begin
          done[i] = 1'b1;
        end
        rdy[i] = ($urandom_range(0, 3) != 0);
        if (vld[i] && rdy[i]) cnt[i] = $urandom_range(1, 12);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
